rx_fifo: RTL and testbench

Receive buffer sitting directly downstream of the UART `Rx` receiver. It captures each byte presented on `Rx`'s `dout` when `rx_done_tick` pulses, and holds it in a circular first-word-fall-through queue until the host logic reads it. It reports empty/full/level to the consumer and records overruns, so a slow consumer never corrupts bytes already queued.

---
 rtl/uart_pkg.sv | 7 +
 rtl/rx_fifo_if.sv | 28 ++
 rtl/rx_fifo_ctrl.sv | 88 ++++++++
 rtl/rx_fifo.sv | 40 ++++
 tb/tb_rx_fifo.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: data width and receive FIFO geometry.
// Used by Rx, Tx, the baud-tick generator and rx_fifo.
package uart_pkg;
   localparam int DBIT       = 8;
   localparam int FIFO_AW    = 4;
   localparam int FIFO_DEPTH = 1 << FIFO_AW;
endpackage

// File: rtl/rx_fifo_if.sv
// Consumer-side bundle of the receive FIFO: write strobe from Rx,
// pop strobe and status back to the host.
interface rx_fifo_if
   import uart_pkg::*;
#(
   parameter int B = DBIT,
   parameter int W = FIFO_AW
);
   logic         wr;
   logic [B-1:0] w_data;
   logic         rd;
   logic         clr_overrun;
   logic [B-1:0] r_data;
   logic         empty;
   logic         full;
   logic [W:0]   count;
   logic         overrun;

   modport master (
      output wr, w_data, rd, clr_overrun,
      input  r_data, empty, full, count, overrun
   );

   modport slave (
      input  wr, w_data, rd, clr_overrun,
      output r_data, empty, full, count, overrun
   );
endinterface

// File: rtl/rx_fifo_ctrl.sv
// Pointer, occupancy and overrun bookkeeping for rx_fifo.
// All status outputs are registered.
module fifo_ctrl
   import uart_pkg::*;
#(
   parameter int W = FIFO_AW
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic         rd,
   input  logic         clr_overrun,
   output logic         we,
   output logic [W-1:0] w_ptr,
   output logic [W-1:0] r_ptr,
   output logic [W:0]   count,
   output logic         empty,
   output logic         full,
   output logic         overrun
);
   localparam logic [W:0] DEPTH = (W+1)'(1 << W);

   logic         do_wr;
   logic         do_rd;
   logic         drop;
   logic [W-1:0] w_ptr_n;
   logic [W-1:0] r_ptr_n;
   logic [W:0]   count_n;
   logic         empty_n;
   logic         full_n;
   logic         overrun_n;

   always_comb begin
      // a pop on a full queue frees the slot for a same-cycle write
      do_wr     = wr & (~full | rd);
      do_rd     = rd & ~empty;
      drop      = wr & full & ~rd;
      w_ptr_n   = w_ptr;
      r_ptr_n   = r_ptr;
      count_n   = count;
      empty_n   = empty;
      full_n    = full;
      overrun_n = overrun;
      unique case ({do_wr, do_rd})
         2'b10: begin
            w_ptr_n = w_ptr + 1'b1;
            count_n = count + 1'b1;
            empty_n = 1'b0;
            full_n  = (count_n == DEPTH);
         end
         2'b01: begin
            r_ptr_n = r_ptr + 1'b1;
            count_n = count - 1'b1;
            full_n  = 1'b0;
            empty_n = (count_n == '0);
         end
         2'b11: begin
            w_ptr_n = w_ptr + 1'b1;
            r_ptr_n = r_ptr + 1'b1;
         end
         default: ;
      endcase
      if (drop)
         overrun_n = 1'b1;
      else if (clr_overrun)
         overrun_n = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr   <= '0;
         r_ptr   <= '0;
         count   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         w_ptr   <= w_ptr_n;
         r_ptr   <= r_ptr_n;
         count   <= count_n;
         empty   <= empty_n;
         full    <= full_n;
         overrun <= overrun_n;
      end
   end

   assign we = do_wr;
endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO behind the UART Rx: first-word-fall-through circular
// buffer with level reporting and sticky overrun.
module rx_fifo
   import uart_pkg::*;
#(
   parameter int B = DBIT,
   parameter int W = FIFO_AW
) (
   input  logic clk,
   input  logic reset,
   rx_fifo_if.slave bus
);
   logic [B-1:0] mem [1 << W];
   logic         we;
   logic [W-1:0] w_ptr;
   logic [W-1:0] r_ptr;

   fifo_ctrl #(.W(W)) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .wr          (bus.wr),
      .rd          (bus.rd),
      .clr_overrun (bus.clr_overrun),
      .we          (we),
      .w_ptr       (w_ptr),
      .r_ptr       (r_ptr),
      .count       (bus.count),
      .empty       (bus.empty),
      .full        (bus.full),
      .overrun     (bus.overrun)
   );

   // storage is deliberately not reset; r_data is meaningless while empty
   always_ff @(posedge clk) begin
      if (we)
         mem[w_ptr] <= bus.w_data;
   end

   assign bus.r_data = mem[r_ptr];
endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: vector table plus multi-cycle
// sequences for fill/overrun, full pass-through, wrap and reset.
module tb_rx_fifo;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;

   rx_fifo_if bus ();

   rx_fifo dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic       clr;
      logic       e;
      logic       f;
      logic [4:0] c;
      logic       o;
      logic       chk_d;
      logic [7:0] d;
   } vec_t;

   vec_t vecs [13];
   logic [7:0] q [$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [7:0] d,
                       input logic p, input logic c);
      reset           = r;
      bus.wr          = w;
      bus.w_data      = d;
      bus.rd          = p;
      bus.clr_overrun = c;
      @(posedge clk);
      #1;
      reset           = 1'b0;
      bus.wr          = 1'b0;
      bus.rd          = 1'b0;
      bus.clr_overrun = 1'b0;
   endtask

   task automatic status(input string tag, input int e, input int f,
                         input int c, input int o);
      chk({tag, ".empty"}, int'(bus.empty), e);
      chk({tag, ".full"}, int'(bus.full), f);
      chk({tag, ".count"}, int'(bus.count), c);
      chk({tag, ".overrun"}, int'(bus.overrun), o);
   endtask

   initial begin
      reset = 1'b0;
      bus.wr = 1'b0;
      bus.w_data = '0;
      bus.rd = 1'b0;
      bus.clr_overrun = 1'b0;
      //           rst wr wd     rd clr e  f  c  o  chk d
      vecs[0]  = '{1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00};
      vecs[1]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00};
      vecs[2]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00};
      vecs[3]  = '{0, 1, 8'hA5, 0, 0, 0, 0, 1, 0, 1, 8'hA5};
      vecs[4]  = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1, 8'hA5};
      vecs[5]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00};
      vecs[6]  = '{0, 1, 8'h11, 0, 0, 0, 0, 1, 0, 1, 8'h11};
      vecs[7]  = '{0, 1, 8'h22, 0, 0, 0, 0, 2, 0, 1, 8'h11};
      vecs[8]  = '{0, 1, 8'h33, 1, 0, 0, 0, 2, 0, 1, 8'h22};
      vecs[9]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 8'h33};
      vecs[10] = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00};
      vecs[11] = '{0, 1, 8'h44, 1, 0, 0, 0, 1, 0, 1, 8'h44};
      vecs[12] = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00};

      @(posedge clk);
      #1;
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
         status($sformatf("vec%0d", i), vecs[i].e, vecs[i].f,
                vecs[i].c, vecs[i].o);
         if (vecs[i].chk_d)
            chk($sformatf("vec%0d.r_data", i), int'(bus.r_data),
                int'(vecs[i].d));
      end

      // fill to full, then drop one
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 8'(i), 0, 0);
         chk("fill.count", int'(bus.count), i + 1);
      end
      status("full", 0, 1, 16, 0);
      step(0, 1, 8'hFF, 0, 0);
      status("drop", 0, 1, 16, 1);
      step(0, 1, 8'hFF, 0, 1);
      status("drop_clr", 0, 1, 16, 1);
      step(0, 0, 8'h00, 0, 1);
      status("clr", 0, 1, 16, 0);
      for (int i = 0; i < 16; i++) begin
         chk("drain.r_data", int'(bus.r_data), i);
         step(0, 0, 8'h00, 1, 0);
      end
      status("drained", 1, 0, 0, 0);

      // refill, then pass-through while full and wrap
      q.delete();
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 8'(8'h10 + i), 0, 0);
         q.push_back(8'(8'h10 + i));
      end
      chk("pt.r_data", int'(bus.r_data), 8'h10);
      step(0, 1, 8'h55, 1, 0);
      void'(q.pop_front());
      q.push_back(8'h55);
      status("pt", 0, 1, 16, 0);
      for (int i = 0; i < 40; i++) begin
         chk("wrap.r_data", int'(bus.r_data), int'(q[0]));
         void'(q.pop_front());
         q.push_back(8'(8'h80 + i));
         step(0, 1, 8'(8'h80 + i), 1, 0);
      end
      status("wrap", 0, 1, 16, 0);
      while (q.size() > 0) begin
         chk("wrap_drain.r_data", int'(bus.r_data), int'(q[0]));
         void'(q.pop_front());
         step(0, 0, 8'h00, 1, 0);
      end
      status("wrap_drained", 1, 0, 0, 0);

      // reset mid-stream
      for (int i = 0; i < 7; i++)
         step(0, 1, 8'(8'hC0 + i), 0, 0);
      chk("pre_rst.count", int'(bus.count), 7);
      step(1, 1, 8'h99, 1, 0);
      status("rst", 1, 0, 0, 0);
      step(0, 1, 8'h3C, 0, 0);
      status("post_rst", 0, 0, 1, 0);
      chk("post_rst.r_data", int'(bus.r_data), 8'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
